// File: rtl/cnn_stream_pkg.sv
// Shared types and constants for the 8-lane fp32 feature-stream blocks.
package cnn_stream_pkg;

  localparam int LANES  = 8;
  localparam int DATA_W = 32;

  typedef logic [LANES-1:0][DATA_W-1:0] lane_vec_t;

  // Bit positions inside err_flags.
  localparam int ERR_DROP  = 0;
  localparam int ERR_UFLOW = 1;
  localparam int ERR_FRAME = 2;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } fork_state_e;

endpackage

// File: rtl/credit_counter.sv
// Up/down credit counter with a full flag and an underflow pulse.
// Shared by every fork/join point that guards a downstream FIFO.
module credit_counter #(
  parameter int DEPTH = 16,
  parameter int W     = $clog2(DEPTH + 1)
) (
  input  logic clk,
  input  logic rst,
  input  logic inc_i,
  input  logic dec_i,
  output logic full_o,
  output logic uflow_o
);

  logic [W-1:0] count_q, count_d;

  // Simultaneous inc/dec cancel; a decrement at zero saturates and is flagged.
  always_comb begin
    count_d = count_q;
    uflow_o = 1'b0;
    if (inc_i && !dec_i) begin
      if (count_q != W'(DEPTH)) count_d = count_q + 1'b1;
    end else if (dec_i && !inc_i) begin
      if (count_q == '0) uflow_o = 1'b1;
      else               count_d = count_q - 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) count_q <= '0;
    else     count_q <= count_d;
  end

  assign full_o = (count_q == W'(DEPTH));

endmodule

// File: rtl/shortcut_fork.sv
// Duplicates one feature stream onto the layer and shortcut branches,
// throttles the source by shortcut-FIFO credits and frames the stream.
module shortcut_fork
  import cnn_stream_pkg::*;
#(
  parameter int FIFO_DEPTH  = 16,
  parameter int FRAME_BEATS = 64,
  parameter int CNT_W       = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       input_valid,
  input  logic       i_sof,
  input  lane_vec_t  d_in,
  output logic       in_ready,
  input  logic       layer_consumed,
  output lane_vec_t  d_out_layer,
  output logic       output_valid_layer,
  output lane_vec_t  d_out_short_cut,
  output logic       output_valid_short_cut,
  output logic       o_sof,
  output logic [2:0] err_flags
);

  logic        accept;
  logic        full;
  logic        uflow;
  lane_vec_t   data_q;
  logic        valid_q;
  logic        sof_q, sof_d;
  fork_state_e state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]  err_q, err_d;

  credit_counter #(.DEPTH(FIFO_DEPTH)) u_credit (
    .clk     (clk),
    .rst     (rst),
    .inc_i   (accept),
    .dec_i   (layer_consumed),
    .full_o  (full),
    .uflow_o (uflow)
  );

  // in_ready depends only on the credit register, never on layer_consumed.
  assign in_ready = !full;
  assign accept   = input_valid && in_ready;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    sof_d   = 1'b0;
    err_d   = err_q;
    if (input_valid && !in_ready) err_d[ERR_DROP] = 1'b1;
    if (uflow)                    err_d[ERR_UFLOW] = 1'b1;
    if (accept) begin
      case (state_q)
        IDLE: begin
          if (i_sof) begin
            sof_d = 1'b1;
            if (FRAME_BEATS == 1) begin
              cnt_d = '0;
            end else begin
              cnt_d   = CNT_W'(1);
              state_d = RUN;
            end
          end else begin
            err_d[ERR_FRAME] = 1'b1;
          end
        end
        RUN: begin
          if (i_sof && cnt_q != '0) begin
            // Early restart: this beat opens a new frame.
            err_d[ERR_FRAME] = 1'b1;
            sof_d            = 1'b1;
            cnt_d            = CNT_W'(1);
          end else if (cnt_q == CNT_W'(FRAME_BEATS - 1)) begin
            cnt_d   = '0;
            state_d = IDLE;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data_q  <= '0;
      valid_q <= 1'b0;
      sof_q   <= 1'b0;
      state_q <= IDLE;
      cnt_q   <= '0;
      err_q   <= '0;
    end else begin
      if (accept) data_q <= d_in;
      valid_q <= accept;
      sof_q   <= sof_d;
      state_q <= state_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
    end
  end

  assign d_out_layer            = data_q;
  assign d_out_short_cut        = data_q;
  assign output_valid_layer     = valid_q;
  assign output_valid_short_cut = valid_q;
  assign o_sof                  = sof_q;
  assign err_flags              = err_q;

endmodule

// File: tb/tb_shortcut_fork.sv
// Directed scoreboard bench for shortcut_fork (FIFO_DEPTH=4, FRAME_BEATS=4).
module tb_shortcut_fork;
  import cnn_stream_pkg::*;

  localparam int DEPTH = 4;
  localparam int FB    = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic       input_valid, i_sof, layer_consumed;
  lane_vec_t  d_in;
  logic       in_ready;
  lane_vec_t  d_out_layer, d_out_short_cut;
  logic       output_valid_layer, output_valid_short_cut, o_sof;
  logic [2:0] err_flags;

  shortcut_fork #(.FIFO_DEPTH(DEPTH), .FRAME_BEATS(FB), .CNT_W(16)) dut (
    .clk                    (clk),
    .rst                    (rst),
    .input_valid            (input_valid),
    .i_sof                  (i_sof),
    .d_in                   (d_in),
    .in_ready               (in_ready),
    .layer_consumed         (layer_consumed),
    .d_out_layer            (d_out_layer),
    .output_valid_layer     (output_valid_layer),
    .d_out_short_cut        (d_out_short_cut),
    .output_valid_short_cut (output_valid_short_cut),
    .o_sof                  (o_sof),
    .err_flags              (err_flags)
  );

  always #5 clk = ~clk;

  typedef struct {
    lane_vec_t data;
    logic      sof;
  } exp_t;

  exp_t      sb[$];
  int        checks   = 0;
  int        failures = 0;
  int        m_occ    = 0;
  bit        m_run    = 1'b0;
  int        m_cnt    = 0;
  logic [2:0] m_err   = '0;
  lane_vec_t m_last   = '0;

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic lane_vec_t mk(input int base);
    lane_vec_t r;
    for (int k = 0; k < LANES; k++) r[k] = DATA_W'(base + k);
    return r;
  endfunction

  task automatic model_reset();
    sb.delete();
    m_occ = 0; m_run = 1'b0; m_cnt = 0; m_err = '0; m_last = '0;
  endtask

  // One clock of stimulus: drive, predict, then check registered outputs.
  task automatic step(input bit v, input bit s, input bit c, input int base);
    bit   acc, rdy, esof;
    exp_t e;
    @(negedge clk);
    input_valid = v; i_sof = s; layer_consumed = c; d_in = mk(base);
    rdy = (m_occ != DEPTH);
    chk("in_ready", 256'(in_ready), 256'(rdy));
    acc  = v && rdy;
    esof = 1'b0;
    if (v && !rdy) m_err[0] = 1'b1;
    if (c && m_occ == 0 && !acc) m_err[1] = 1'b1;
    if (acc && !c) m_occ++;
    else if (c && !acc && m_occ > 0) m_occ--;
    if (acc) begin
      if (!m_run) begin
        if (s) begin
          esof = 1'b1;
          if (FB > 1) begin m_run = 1'b1; m_cnt = 1; end
        end else m_err[2] = 1'b1;
      end else if (s) begin
        m_err[2] = 1'b1; esof = 1'b1; m_cnt = 1;
      end else if (m_cnt == FB - 1) begin
        m_cnt = 0; m_run = 1'b0;
      end else m_cnt++;
      e.data = mk(base); e.sof = esof;
      sb.push_back(e);
      m_last = mk(base);
    end
    @(posedge clk); #1;
    chk("valid_layer", 256'(output_valid_layer), 256'(acc));
    chk("valid_short", 256'(output_valid_short_cut), 256'(acc));
    if (output_valid_layer) begin
      checks++;
      assert (sb.size() != 0) else begin
        failures++;
        $error("FAIL sb_underrun observed=valid expected=no_output");
      end
      if (sb.size() != 0) begin
        e = sb.pop_front();
        chk("d_layer", d_out_layer, e.data);
        chk("d_short", d_out_short_cut, e.data);
        chk("o_sof", 256'(o_sof), 256'(e.sof));
      end
    end else begin
      chk("hold_layer", d_out_layer, m_last);
      chk("sof_idle", 256'(o_sof), 256'(0));
    end
    chk("err_flags", 256'(err_flags), 256'(m_err));
  endtask

  initial begin
    rst = 1'b1; input_valid = 1'b0; i_sof = 1'b0; layer_consumed = 1'b0; d_in = '0;
    #12;
    chk("rst_in_ready", 256'(in_ready), 256'(1));
    chk("rst_valid", 256'(output_valid_layer), 256'(0));
    chk("rst_sof", 256'(o_sof), 256'(0));
    chk("rst_err", 256'(err_flags), 256'(0));
    chk("rst_data", d_out_short_cut, 256'(0));
    @(negedge clk); rst = 1'b0;

    // Single frame, consume two cycles after each output.
    step(1, 1, 0, 0); step(1, 0, 0, 1); step(1, 0, 0, 2); step(1, 0, 1, 3);
    step(0, 0, 1, 0); step(0, 0, 1, 0); step(0, 0, 1, 0); step(0, 0, 0, 0);

    // Underflow, then a clean frame.
    step(0, 0, 1, 0);
    step(1, 1, 1, 10); step(1, 0, 1, 11); step(1, 0, 1, 12); step(1, 0, 1, 13);

    // Backpressure: six beats, no consumption.
    for (int b = 0; b < 6; b++) step(1, b == 0, 0, 20 + b);
    step(0, 0, 1, 0);
    // occ = DEPTH-1: accept + consume together, then accept alone fills.
    step(1, 1, 1, 30);
    step(1, 0, 0, 31);
    step(1, 0, 0, 32);
    for (int b = 0; b < DEPTH; b++) step(0, 0, 1, 0);
    step(1, 0, 0, 33); step(1, 0, 1, 34);

    // Early restart at beat 2, then a run without i_sof.
    step(1, 1, 1, 40); step(1, 0, 1, 41); step(1, 1, 1, 42);
    step(1, 0, 1, 43); step(1, 0, 1, 44); step(1, 0, 1, 45);
    step(1, 0, 1, 50); step(1, 0, 1, 51);

    // Reset mid-frame while beat 2 is presented.
    step(1, 1, 0, 60); step(1, 0, 0, 61);
    @(negedge clk);
    input_valid = 1'b1; i_sof = 1'b0; layer_consumed = 1'b0; d_in = mk(62);
    #2 rst = 1'b1;
    #1;
    chk("mid_rst_valid", 256'(output_valid_layer), 256'(0));
    chk("mid_rst_vshort", 256'(output_valid_short_cut), 256'(0));
    chk("mid_rst_data", d_out_layer, 256'(0));
    chk("mid_rst_sof", 256'(o_sof), 256'(0));
    chk("mid_rst_err", 256'(err_flags), 256'(0));
    chk("mid_rst_ready", 256'(in_ready), 256'(1));
    input_valid = 1'b0;
    @(negedge clk); rst = 1'b0;
    model_reset();
    step(1, 1, 0, 70); step(1, 0, 0, 71); step(0, 0, 1, 0); step(0, 0, 1, 0);

    checks++;
    assert (sb.size() == 0) else begin
      failures++;
      $error("FAIL sb_leftover observed=%0d expected=0", sb.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
